// File: rtl/vedic_mult16_seq_ctrl_pkg.sv
// Shared definitions for the sequential 16x16 multiplier built on one 8x8 core.
// Holds the FSM state encoding, the per-pass partial-product shift amounts and
// the per-pass byte selects, so that other controllers reusing the same shared
// core can follow the identical pass order.
package vedic_mult16_seq_ctrl_pkg;

  // Binary-encoded controller states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam int NUM_PASSES = 4;

  // Left shift applied to each pass's 16-bit partial before accumulation.
  localparam logic [4:0] PASS0_SHIFT = 5'd0;   // a_lo * b_lo
  localparam logic [4:0] PASS1_SHIFT = 5'd8;   // a_hi * b_lo
  localparam logic [4:0] PASS2_SHIFT = 5'd8;   // a_lo * b_hi
  localparam logic [4:0] PASS3_SHIFT = 5'd16;  // a_hi * b_hi

  // Byte selects: bit n set means pass n feeds the high byte of that operand.
  localparam logic [NUM_PASSES-1:0] PASS_A_HI = 4'b1010;
  localparam logic [NUM_PASSES-1:0] PASS_B_HI = 4'b1100;

  function automatic logic [4:0] pass_shift(input logic [1:0] idx);
    logic [4:0] sh;
    case (idx)
      2'd0:    sh = PASS0_SHIFT;
      2'd1:    sh = PASS1_SHIFT;
      2'd2:    sh = PASS2_SHIFT;
      default: sh = PASS3_SHIFT;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/vedic_mult16_seq_ctrl_vedic_8X8.sv
// vedic_8X8: purely combinational 8x8 unsigned multiplier (Urdhva-Tiryakbhyam
// on nibbles). Vertical products of the low and high nibbles plus the crosswise
// sum, combined with 4-bit offsets.
// Ports:
//   i_a  in  8   multiplicand
//   i_b  in  8   multiplier
//   o_p  out 16  product i_a*i_b
module vedic_8X8 (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);

  logic [7:0] w_ll;
  logic [7:0] w_lh;
  logic [7:0] w_hl;
  logic [7:0] w_hh;
  logic [8:0] w_cross;

  // Operands are widened first so each nibble product keeps all 8 bits.
  assign w_ll    = {4'd0, i_a[3:0]} * {4'd0, i_b[3:0]};
  assign w_lh    = {4'd0, i_a[7:4]} * {4'd0, i_b[3:0]};
  assign w_hl    = {4'd0, i_a[3:0]} * {4'd0, i_b[7:4]};
  assign w_hh    = {4'd0, i_a[7:4]} * {4'd0, i_b[7:4]};
  assign w_cross = {1'b0, w_lh} + {1'b0, w_hl};

  assign o_p = {8'd0, w_ll} + {3'd0, w_cross, 4'd0} + {w_hh, 8'd0};

endmodule

// File: rtl/vedic_mult16_seq_ctrl.sv
// vedic_mult16_seq_ctrl: 16x16 unsigned multiplier that time-shares a single
// vedic_8X8 core over four one-cycle passes, shift-accumulating into 32 bits.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      block can accept operands (IDLE only)
//   in_a       in   16     multiplicand, unsigned
//   in_b       in   16     multiplier, unsigned
//   in_tag     in   TAG_W  tag returned with the result
//   out_valid  out  1      product valid, held until out_ready
//   out_ready  in   1      consumer accepts product
//   out_p      out  32     product
//   out_tag    out  TAG_W  tag of the product
//   busy       out  1      controller not in IDLE
module vedic_mult16_seq_ctrl
  import vedic_mult16_seq_ctrl_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  state_t           r_state;
  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_acc;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [31:0]      r_out_p;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_busy;

  logic [1:0]  w_pass_idx;
  logic [7:0]  w_core_a;
  logic [7:0]  w_core_b;
  logic [15:0] w_pp;
  logic [31:0] w_pp_shifted;
  logic [31:0] w_acc_sum;

  // Pass index follows the state; outside P0..P3 the core output is unused.
  always_comb begin
    w_pass_idx = 2'd0;
    case (r_state)
      ST_P1:   w_pass_idx = 2'd1;
      ST_P2:   w_pass_idx = 2'd2;
      ST_P3:   w_pass_idx = 2'd3;
      default: w_pass_idx = 2'd0;
    endcase
  end

  // Core operands come only from the latched copies, so the input ports may
  // change freely once an operation has been accepted.
  assign w_core_a = PASS_A_HI[w_pass_idx] ? r_a[15:8] : r_a[7:0];
  assign w_core_b = PASS_B_HI[w_pass_idx] ? r_b[15:8] : r_b[7:0];

  vedic_8X8 u_core (
    .i_a (w_core_a),
    .i_b (w_core_b),
    .o_p (w_pp)
  );

  assign w_pp_shifted = {16'd0, w_pp} << pass_shift(w_pass_idx);
  // The accumulator is cleared on acceptance, so in P0 this sum is just pp.
  assign w_acc_sum    = r_acc + w_pp_shifted;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_tag       <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_p     <= '0;
      r_out_tag   <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_tag      <= in_tag;
            r_acc      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_P0;
          end
        end
        ST_P0: begin
          r_acc   <= w_acc_sum;
          r_state <= ST_P1;
        end
        ST_P1: begin
          r_acc   <= w_acc_sum;
          r_state <= ST_P2;
        end
        ST_P2: begin
          r_acc   <= w_acc_sum;
          r_state <= ST_P3;
        end
        ST_P3: begin
          // Final sum goes straight to the output register so the product is
          // presented on the first DONE cycle.
          r_acc       <= w_acc_sum;
          r_out_p     <= w_acc_sum;
          r_out_tag   <= r_tag;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_p     = r_out_p;
  assign out_tag   = r_out_tag;
  assign busy      = r_busy;

endmodule

// File: tb/tb_vedic_mult16_seq_ctrl.sv
module tb_vedic_mult16_seq_ctrl;

  localparam int TAG_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_p;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  vedic_mult16_seq_ctrl #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      a;
    logic [15:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp_p;
  } vec_t;

  typedef struct {
    logic [31:0]      p;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cycle   = 0;
  int   last_hs_cycle = -1;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", name, act);
    end
  endtask

  // Output monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      last_hs_cycle = cycle;
      if (sb_q.size() == 0) begin
        check("unexpected_output", out_p, 32'hDEAD_BEEF);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("product tag%0d", e.tag), out_p, e.p);
        check("out_tag", {{(32-TAG_W){1'b0}}, out_tag}, {{(32-TAG_W){1'b0}}, e.tag});
      end
    end
  end

  // Drive one operation and hold it until accepted; the expected result is
  // pushed at the acceptance cycle.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [TAG_W-1:0] tag, output int acc_cycle);
    exp_t e;
    bit   done;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    in_valid = 1'b1;
    acc_cycle = -1;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.p   = {16'd0, a} * {16'd0, b};
        e.tag = tag;
        sb_q.push_back(e);
        acc_cycle = cycle;
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 16'hFFFF;  // post-acceptance changes must not affect the result
    in_b     = 16'hFFFF;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
  endtask

  vec_t vecs[6];
  int   acc_c, acc_c2, edges;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;

    vecs[0] = '{16'h1234, 16'h5678, 4'd3, 32'h0626_0060};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 4'd1, 32'hFFFE_0001};
    vecs[2] = '{16'h0000, 16'hABCD, 4'd2, 32'h0000_0000};
    vecs[3] = '{16'h0001, 16'hABCD, 4'd6, 32'h0000_ABCD};
    vecs[4] = '{16'h00FF, 16'h0100, 4'd7, 32'h0000_FF00};
    vecs[5] = '{16'h8000, 16'h0002, 4'd9, 32'h0001_0000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready",  {31'd0, in_ready},  32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_p",     out_p,              32'd0);
    check("rst out_tag",   {28'd0, out_tag},   32'd0);
    check("rst busy",      {31'd0, busy},      32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency: accepted in cycle T0, out_valid visible in cycle T0+5.
    out_ready = 1'b0;
    issue(vecs[0].a, vecs[0].b, vecs[0].tag, acc_c);
    wait_valid(edges);
    check("latency_edges_after_accept", edges, 32'd4);
    check("table0 out_p const", out_p, vecs[0].exp_p);
    out_ready = 1'b1;
    drain();

    // Table: known constants, checked directly and via the scoreboard.
    for (int i = 1; i < 6; i++) begin
      out_ready = 1'b0;
      issue(vecs[i].a, vecs[i].b, vecs[i].tag, acc_c);
      wait_valid(edges);
      check($sformatf("table%0d out_p const", i), out_p, vecs[i].exp_p);
      out_ready = 1'b1;
      drain();
    end

    // Random back-to-back operations.
    for (int i = 0; i < 8; i++) begin
      issue(16'($urandom), 16'($urandom), 4'(i), acc_c);
    end
    drain();

    // Backpressure: out_ready low for three DONE cycles.
    out_ready = 1'b0;
    issue(16'h1357, 16'h2468, 4'd5, acc_c);
    wait_valid(edges);
    for (int i = 0; i < 3; i++) begin
      check("bp out_valid", {31'd0, out_valid}, 32'd1);
      check("bp out_p",     out_p,              32'h1357 * 32'h2468);
      check("bp out_tag",   {28'd0, out_tag},   32'd5);
      check("bp in_ready",  {31'd0, in_ready},  32'd0);
      check("bp busy",      {31'd0, busy},      32'd1);
      if (i < 2) begin
        @(posedge clk);
        #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release out_valid", {31'd0, out_valid}, 32'd0);
    check("bp release in_ready",  {31'd0, in_ready},  32'd1);

    // Held request: second operand accepted the cycle after the first handshake.
    issue(16'h0102, 16'h0304, 4'd3, acc_c);
    issue(16'h0506, 16'h0708, 4'd4, acc_c2);
    check("second accept cycle", acc_c2, last_hs_cycle + 1);
    drain();

    // Reset while in P2 discards the operation.
    issue(16'h4321, 16'h8765, 4'd8, acc_c);   // now in P0
    @(posedge clk); #1;                       // P1
    @(posedge clk); #1;                       // P2
    check("pre-rst busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    check("mid-rst in_ready",  {31'd0, in_ready},  32'd1);
    check("mid-rst out_valid", {31'd0, out_valid}, 32'd0);
    check("mid-rst busy",      {31'd0, busy},      32'd0);
    repeat (8) @(posedge clk);  // monitor flags any stale output
    #1;
    issue(16'h00FF, 16'h0100, 4'd2, acc_c);
    wait_valid(edges);
    check("post-rst out_p", out_p, 32'h0000_FF00);
    drain();

    check("scoreboard empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
